// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared types, opcodes and the immediate extraction function
// used by the imm_gen_pipe decode stage.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_SH   = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_t;

  // Occupancy of the two-entry elastic buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Immediates are always built at 64 bits; callers keep the low XLEN bits,
  // which is a correct sign/zero extension for XLEN=32 as well.
  localparam int IMM_MAX_W = 64;

  typedef struct packed {
    imm_fmt_t               fmt;
    logic [IMM_MAX_W-1:0]   imm;
  } imm_dec_t;

  // Decode the format and extended immediate of one instruction word.
  function automatic imm_dec_t imm_extract(input logic [31:0] inst, input int xlen);
    imm_dec_t   r;
    logic [2:0] f3;
    logic       is_shift;
    r.fmt    = FMT_NONE;
    r.imm    = '0;
    f3       = inst[14:12];
    is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    case (inst[6:0])
      OPC_OP_IMM: begin
        if (is_shift) begin
          r.fmt = FMT_SH;
          // funct7/funct6 sit above the shamt field and are never copied.
          if (xlen == 64) r.imm = {58'b0, inst[25:20]};
          else            r.imm = {59'b0, inst[24:20]};
        end else begin
          r.fmt = FMT_I;
          r.imm = {{52{inst[31]}}, inst[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        r.fmt = FMT_I;
        r.imm = {{52{inst[31]}}, inst[31:20]};
      end
      OPC_OP_IMM_32: begin
        // The word ops only exist on RV64; on RV32 they are unknown opcodes.
        if (xlen == 64) begin
          if (is_shift) begin
            r.fmt = FMT_SH;
            r.imm = {59'b0, inst[24:20]};
          end else begin
            r.fmt = FMT_I;
            r.imm = {{52{inst[31]}}, inst[31:20]};
          end
        end
      end
      OPC_STORE: begin
        r.fmt = FMT_S;
        r.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        r.fmt = FMT_B;
        r.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        r.fmt = FMT_J;
        r.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        r.fmt = FMT_U;
        r.imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      end
      OPC_SYSTEM: begin
        if (f3[2]) begin
          r.fmt = FMT_Z;
          r.imm = {59'b0, inst[19:15]};
        end else begin
          r.fmt = FMT_I;
          r.imm = {{52{inst[31]}}, inst[31:20]};
        end
      end
      default: begin
        r.fmt = FMT_NONE;
        r.imm = '0;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_skid_buf.sv
// imm_skid_buf: generic two-entry valid/ready elastic buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and ready (in_ready_o) comes
// straight from a register so no combinational path crosses the buffer.
// Entries leave in the order they arrived; flush empties the buffer and
// outranks any same-cycle transfer.
module imm_skid_buf
  import imm_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output buf_state_t   state_o
);

  buf_state_t   state_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  // Occupancy FSM with registered ready/valid and the two data slots.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
    end else if (flush_i) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire) begin
            out_q       <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            out_q <= in_data_i;
          end else if (in_fire) begin
            // Downstream stalled: park the new entry behind the output.
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= BUF_FULL;
          end else if (out_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (out_fire) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= BUF_ONE;
          end
        end
        default: begin
          state_q     <= BUF_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;
  assign state_o     = state_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate extractor with a registered,
// two-entry elastic output stream. Optional per-format perf counters are
// enabled with the IMM_GEN_PERF_EN macro.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output buf_state_t       dbg_state
`ifdef IMM_GEN_PERF_EN
  ,
  output logic [8*CNT_W-1:0] perf_cnt
`endif
);

  localparam int PW = TAG_W + 3 + XLEN;

  imm_dec_t      dec;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  logic          unused_imm_bits;

  // Combinational decode of the offered instruction.
  always_comb begin
    dec = imm_extract(in_inst, XLEN);
  end

  // Upper immediate bits are dropped when XLEN=32.
  assign unused_imm_bits = ^dec.imm;

  assign in_payload = {in_tag, dec.fmt, dec.imm[XLEN-1:0]};

  imm_skid_buf #(
    .W (PW)
  ) u_buf (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_payload),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_payload),
    .state_o     (dbg_state)
  );

  assign out_imm = out_payload[XLEN-1:0];
  assign out_fmt = out_payload[XLEN +: 3];
  assign out_tag = out_payload[XLEN+3 +: TAG_W];

`ifdef IMM_GEN_PERF_EN
  logic [CNT_W-1:0] perf_q [8];
  logic             cnt_fire;

  // A flushed output never reaches execute, so it is not counted.
  assign cnt_fire = out_valid & out_ready & ~flush;

  // Saturating per-format counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) perf_q[i] <= '0;
    end else if (cnt_fire && (perf_q[out_fmt] != {CNT_W{1'b1}})) begin
      perf_q[out_fmt] <= perf_q[out_fmt] + 1'b1;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_perf
    assign perf_cnt[g*CNT_W +: CNT_W] = perf_q[g];
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe (XLEN=32 main instance,
// XLEN=64 side instance for RV64-only formats). Honours IMM_GEN_PERF_EN.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int TAG_W    = 32;
  localparam int TB_CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, flush, in_valid, out_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready, out_valid;
  logic [31:0]      out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  buf_state_t       dbg_state;

  logic             in_ready64, out_valid64;
  logic             out_ready64;
  logic [63:0]      out_imm64;
  logic [2:0]       out_fmt64;
  logic [TAG_W-1:0] out_tag64;
  buf_state_t       dbg_state64;

`ifdef IMM_GEN_PERF_EN
  logic [8*TB_CNT_W-1:0] perf_cnt;
  logic [8*TB_CNT_W-1:0] perf_cnt64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(TB_CNT_W)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_tag(out_tag), .dbg_state(dbg_state)
`ifdef IMM_GEN_PERF_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .CNT_W(TB_CNT_W)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_tag(out_tag64), .dbg_state(dbg_state64)
`ifdef IMM_GEN_PERF_EN
    , .perf_cnt(perf_cnt64)
`endif
  );

  assign out_ready64 = 1'b1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [TAG_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    in_valid = v;
    in_inst  = inst;
    in_tag   = tag;
  endtask

  // Directed vectors with hand-computed results for both XLEN builds.
  localparam int NV = 12;
  logic [31:0] v_inst  [NV] = '{32'hFFF00093, 32'hFFC02083, 32'hFE000CE3, 32'h123450B7,
                                32'h4030D093, 32'h01F09093, 32'h03F09093, 32'hFE20AE23,
                                32'h0080006F, 32'h0002D073, 32'hFFFFFFFF, 32'hFFF0009B};
  logic [31:0] e_imm32 [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                32'h00000003, 32'h0000001F, 32'h0000001F, 32'hFFFFFFFC,
                                32'h00000008, 32'h00000005, 32'h00000000, 32'h00000000};
  logic [2:0]  e_fmt32 [NV] = '{3'd1, 3'd1, 3'd4, 3'd5, 3'd2, 3'd2, 3'd2, 3'd3,
                                3'd6, 3'd7, 3'd0, 3'd0};
  logic [63:0] e_imm64 [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFF8, 64'h0000000012345000,
                                64'h3, 64'h1F, 64'h3F, 64'hFFFFFFFFFFFFFFFC,
                                64'h8, 64'h5, 64'h0, 64'hFFFFFFFFFFFFFFFF};
  logic [2:0]  e_fmt64 [NV] = '{3'd1, 3'd1, 3'd4, 3'd5, 3'd2, 3'd2, 3'd2, 3'd3,
                                3'd6, 3'd7, 3'd0, 3'd1};

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int sent, rcvd;
    logic [TAG_W-1:0] exp_tag;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, '0);
    step(); step();

    // Reset values.
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_imm",   64'(out_imm),   64'd0);
    chk("rst_out_fmt",   64'(out_fmt),   64'(FMT_NONE));
    chk("rst_out_tag",   64'(out_tag),   64'd0);
    chk("rst_state",     64'(dbg_state), 64'(BUF_EMPTY));
    rst = 1'b0;

    // Back-to-back stream, one result per cycle with one cycle latency.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, v_inst[i], TAG_W'(32'h1000 + i));
      step();
      chk("str_in_ready",  64'(in_ready),  64'd1);
      chk("str_valid",     64'(out_valid), 64'd1);
      chk("str_imm32",     64'(out_imm),   64'(e_imm32[i]));
      chk("str_fmt32",     64'(out_fmt),   64'(e_fmt32[i]));
      chk("str_tag",       64'(out_tag),   64'(32'h1000 + i));
      chk("str_imm64",     out_imm64,      e_imm64[i]);
      chk("str_fmt64",     64'(out_fmt64), 64'(e_fmt64[i]));
    end
    drive(1'b0, 32'h0, '0);
    step();
    chk("str_drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: five inputs, out_ready low for the first three cycles.
    sent = 0; rcvd = 0;
    for (int c = 0; c < 30 && rcvd < 5; c++) begin
      out_ready = (c >= 3);
      drive(sent < 5, 32'hFFF00093, TAG_W'(32'h100 + sent));
      if (c == 1) begin
        chk("bp_ready_after1", 64'(in_ready),  64'd1);
        chk("bp_hold_tag1",    64'(out_tag),   64'h100);
      end
      if (c == 2) begin
        chk("bp_ready_after2", 64'(in_ready),  64'd0);
        chk("bp_state_full",   64'(dbg_state), 64'(BUF_FULL));
        chk("bp_hold_tag2",    64'(out_tag),   64'h100);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_tag);
        sent++;
      end
      if (out_ready && rcvd < 5) chk("bp_no_gap", 64'(out_valid), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) begin
          exp_tag = exp_q.pop_front();
          chk("bp_order_tag", 64'(out_tag), 64'(exp_tag));
        end else begin
          chk("bp_unexpected_out", 64'(out_tag), 64'hDEAD);
        end
        rcvd++;
      end
      step();
    end
    chk("bp_received", 64'(rcvd), 64'd5);
    drive(1'b0, 32'h0, '0);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush while FULL with a new instruction offered.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h200); step();
    drive(1'b1, 32'hFFF00093, 32'h201); step();
    chk("fl_full_state", 64'(dbg_state), 64'(BUF_FULL));
    drive(1'b1, 32'hFFF00093, 32'h202);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    chk("fl_valid",    64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready),  64'd1);
    chk("fl_state",    64'(dbg_state), 64'(BUF_EMPTY));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fl_no_reappear", 64'(out_valid), 64'd0);
    end

    // Flush in ONE with an acceptable input: that input is not captured.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h203); step();
    drive(1'b1, 32'hFFF00093, 32'h204);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    chk("fl1_valid", 64'(out_valid), 64'd0);
    step();
    chk("fl1_still_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h0002D073, 32'h205); step();
    chk("fl_post_tag", 64'(out_tag), 64'h205);
    chk("fl_post_imm", 64'(out_imm), 64'h5);
    drive(1'b0, 32'h0, '0); step();

    // Reset mid-stream with the buffer full.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFC02083, 32'h300); step();
    drive(1'b1, 32'hFFC02083, 32'h301); step();
    drive(1'b1, 32'hFFC02083, 32'h302);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_valid",    64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready),  64'd1);
    chk("mrst_imm",      64'(out_imm),   64'd0);
    chk("mrst_fmt",      64'(out_fmt),   64'(FMT_NONE));
    chk("mrst_tag",      64'(out_tag),   64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h123450B7, 32'h400); step();
    chk("mrst_post_valid", 64'(out_valid), 64'd1);
    chk("mrst_post_tag",   64'(out_tag),   64'h400);
    chk("mrst_post_imm",   64'(out_imm),   64'h12345000);
    chk("mrst_post_fmt",   64'(out_fmt),   64'(FMT_U));
    drive(1'b0, 32'h0, '0); step();

`ifdef IMM_GEN_PERF_EN
    // Perf counters: a stalled output does not count; 20 FMT_I saturate at 0xF.
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'h500); step();
    drive(1'b0, 32'h0, '0); step(); step();
    chk("perf_stalled_i", 64'(perf_cnt[1*TB_CNT_W +: TB_CNT_W]), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 19; k++) begin
      drive(1'b1, 32'hFFF00093, TAG_W'(32'h501 + k));
      step();
    end
    drive(1'b0, 32'h0, '0);
    step(); step();
    for (int f = 0; f < 8; f++) begin
      chk("perf_cnt", 64'(perf_cnt[f*TB_CNT_W +: TB_CNT_W]), (f == 1) ? 64'hF : 64'd0);
    end
`endif

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
